tug_war_referee: RTL and testbench

//  Referee/arbiter for the tug-of-war playfield built from the chained light cells.

---
 rtl/tug_pkg.sv | 5 +
 rtl/tug_war_referee_if.sv | 15 +
 rtl/tug_war_referee_key_edge.sv | 17 +
 rtl/tug_war_referee.sv | 88 ++++++++
 tb/tb_tug_war_referee.sv | 237 +++++++++++++++++++++++
 5 files changed

// File: rtl/tug_pkg.sv
// Shared types for the tug-of-war referee: FSM states and player identity.
package tug_pkg;
  typedef enum logic [1:0] {PLAY, ROUND_END, MATCH_OVER} ref_state_t;
  typedef enum logic {P_LEFT, P_RIGHT} player_t;
endpackage

// File: rtl/tug_war_referee_if.sv
// Referee bus: key/win inputs from the field side, pulses and scores back out.
interface tug_war_referee_if #(parameter int SCORE_W = 3);
  logic               keyL, keyR;
  logic               leftWin, rightWin;
  logic               L, R;
  logic               fieldReset;
  logic [SCORE_W-1:0] scoreL, scoreR;
  logic               matchOver;
  logic               matchWinner;

  modport master (output keyL, keyR, leftWin, rightWin,
                  input  L, R, fieldReset, scoreL, scoreR, matchOver, matchWinner);
  modport slave  (input  keyL, keyR, leftWin, rightWin,
                  output L, R, fieldReset, scoreL, scoreR, matchOver, matchWinner);
endinterface

// File: rtl/tug_war_referee_key_edge.sv
// Rising-edge press detector for one synchronised key level.
module key_edge (
  input  logic Clock,
  input  logic Reset,
  input  logic key,
  output logic press
);
  logic key_d;

  // History resets to 1 so a key held through Reset never looks like a new press.
  always_ff @(posedge Clock) begin
    if (Reset) key_d <= 1'b1;
    else       key_d <= key;
  end

  assign press = key & ~key_d;
endmodule

// File: rtl/tug_war_referee.sv
// Tug-of-war referee: key pulses, round scoring, playfield clear hold, match end.
module tug_war_referee
  import tug_pkg::*;
#(
  parameter int SCORE_W     = 3,
  parameter int TARGET      = 7,
  parameter int HOLD_CYCLES = 4
) (
  input  logic              Clock,
  input  logic              Reset,
  tug_war_referee_if.slave  bus
);
  localparam int                 CW  = $clog2(HOLD_CYCLES + 1);
  localparam logic [SCORE_W-1:0] TGT = SCORE_W'(TARGET);
  localparam logic [SCORE_W-1:0] ONE = SCORE_W'(1);

  ref_state_t         state, state_nxt;
  logic               pressL, pressR;
  logic               l_q, r_q;
  logic [CW-1:0]      hold_cnt;
  logic [SCORE_W-1:0] scoreL, scoreR;
  player_t            winner;
  logic               at_target, pass_keys;

  key_edge u_key_l (.Clock(Clock), .Reset(Reset), .key(bus.keyL), .press(pressL));
  key_edge u_key_r (.Clock(Clock), .Reset(Reset), .key(bus.keyR), .press(pressR));

  assign at_target = (scoreL == TGT) || (scoreR == TGT);
  // Keys only reach the field when we stay in PLAY; a win this cycle drops them.
  assign pass_keys = (state == PLAY) && (state_nxt == PLAY);

  always_ff @(posedge Clock) begin
    if (Reset) state <= PLAY;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      PLAY:       if (bus.leftWin || bus.rightWin) state_nxt = ROUND_END;
      ROUND_END:  if (hold_cnt <= CW'(1)) state_nxt = at_target ? MATCH_OVER : PLAY;
      MATCH_OVER: state_nxt = MATCH_OVER;
      default:    state_nxt = PLAY;
    endcase
  end

  always_comb begin
    bus.fieldReset = (state != PLAY);
    bus.matchOver  = (state == MATCH_OVER);
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      l_q      <= 1'b0;
      r_q      <= 1'b0;
      hold_cnt <= '0;
      scoreL   <= '0;
      scoreR   <= '0;
      winner   <= P_LEFT;
    end else begin
      l_q <= pass_keys & pressL & ~pressR;
      r_q <= pass_keys & pressR & ~pressL;

      if (state == PLAY && state_nxt == ROUND_END)
        hold_cnt <= CW'(HOLD_CYCLES);
      else if (state == ROUND_END && hold_cnt > CW'(1))
        hold_cnt <= hold_cnt - CW'(1);

      // Simultaneous wins score nobody; the round still ends.
      if (state == PLAY) begin
        if (bus.leftWin && !bus.rightWin) begin
          scoreL <= scoreL + ONE;
          if (scoreL + ONE == TGT) winner <= P_LEFT;
        end
        if (bus.rightWin && !bus.leftWin) begin
          scoreR <= scoreR + ONE;
          if (scoreR + ONE == TGT) winner <= P_RIGHT;
        end
      end
    end
  end

  assign bus.L           = l_q;
  assign bus.R           = r_q;
  assign bus.scoreL      = scoreL;
  assign bus.scoreR      = scoreR;
  assign bus.matchWinner = (winner == P_RIGHT);
endmodule

// File: tb/tb_tug_war_referee.sv
// Randomised and directed checks of tug_war_referee against a rule-level model.
module tb_tug_war_referee;
  localparam int SW = 3, T = 3, H = 4;

  logic Clock = 1'b0;
  logic Reset;
  always #5 Clock = ~Clock;

  tug_war_referee_if #(.SCORE_W(SW)) bus ();

  tug_war_referee #(.SCORE_W(SW), .TARGET(T), .HOLD_CYCLES(H)) dut (
    .Clock(Clock), .Reset(Reset), .bus(bus)
  );

  int n_cmp = 0, n_err = 0;

  // Reference model: mode 0 = playing, 1 = clearing the field, 2 = match decided.
  int m_mode, m_hold, m_sl, m_sr;
  bit m_win, m_L, m_R, m_kl, m_kr;

  function automatic logic [10:0] exp_vec();
    return {m_L, m_R, (m_mode != 0), 3'(m_sl), 3'(m_sr), (m_mode == 2), m_win};
  endfunction

  function automatic logic [10:0] obs_vec();
    return {bus.L, bus.R, bus.fieldReset, bus.scoreL, bus.scoreR, bus.matchOver, bus.matchWinner};
  endfunction

  task automatic drive(input bit kl, input bit kr, input bit lw, input bit rw, input bit rst);
    bit pl, pr, nL, nR;
    bus.keyL = kl; bus.keyR = kr; bus.leftWin = lw; bus.rightWin = rw; Reset = rst;
    if (rst) begin
      m_mode = 0; m_hold = 0; m_sl = 0; m_sr = 0; m_win = 0;
      m_L = 0; m_R = 0; m_kl = 1; m_kr = 1;
    end else begin
      pl = kl && !m_kl; pr = kr && !m_kr; nL = 0; nR = 0;
      case (m_mode)
        0: if (lw || rw) begin
             if (lw && !rw) begin m_sl++; if (m_sl == T) m_win = 0; end
             if (rw && !lw) begin m_sr++; if (m_sr == T) m_win = 1; end
             m_mode = 1; m_hold = H;
           end else begin
             nL = pl && !pr; nR = pr && !pl;
           end
        1: begin
             m_hold--;
             if (m_hold == 0) m_mode = (m_sl == T || m_sr == T) ? 2 : 0;
           end
        default: ;
      endcase
      m_L = nL; m_R = nR; m_kl = kl; m_kr = kr;
    end
    @(posedge Clock); #1;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 2; i++) drive(1, 1, 0, 0, 1);
    n_cmp++;
    if (obs_vec() !== 11'd0) begin
      n_err++; $display("FAIL reset_state: got %b want %b", obs_vec(), 11'd0);
    end
    for (int i = 0; i < 3; i++) begin
      drive(1, 1, 0, 0, 0);
      n_cmp++;
      if (obs_vec() !== exp_vec()) begin
        n_err++; $display("FAIL reset_held_keys cyc%0d: got %b want %b", i, obs_vec(), exp_vec());
      end
    end
    drive(0, 0, 0, 0, 0);
  endtask

  task automatic test_press_hold();
    int lcnt = 0, rcnt = 0;
    for (int i = 0; i < 4; i++) drive(0, 0, 0, 0, 0);
    for (int i = 0; i < 10; i++) begin
      drive(1, 0, 0, 0, 0);
      lcnt += int'(bus.L); rcnt += int'(bus.R);
      n_cmp++;
      if (obs_vec() !== exp_vec()) begin
        n_err++; $display("FAIL press_hold cyc%0d: got %b want %b", i, obs_vec(), exp_vec());
      end
      if (i == 0) begin
        n_cmp++;
        if (bus.L !== 1'b1) begin
          n_err++; $display("FAIL press_latency: L got %b want 1", bus.L);
        end
      end
    end
    n_cmp++;
    if (lcnt != 1 || rcnt != 0) begin
      n_err++; $display("FAIL press_count: L=%0d R=%0d want L=1 R=0", lcnt, rcnt);
    end
    drive(0, 0, 0, 0, 0);
  endtask

  task automatic test_tie();
    drive(1, 1, 0, 0, 0);
    n_cmp++;
    if (bus.L !== 1'b0 || bus.R !== 1'b0) begin
      n_err++; $display("FAIL tie: L=%b R=%b want 0 0", bus.L, bus.R);
    end
    drive(0, 0, 0, 0, 0); drive(0, 0, 0, 0, 0);
    drive(0, 1, 0, 0, 0);
    n_cmp++;
    if (bus.R !== 1'b1 || bus.L !== 1'b0) begin
      n_err++; $display("FAIL tie_then_r: L=%b R=%b want 0 1", bus.L, bus.R);
    end
    for (int i = 0; i < 3; i++) begin
      drive(0, 1, 0, 0, 0);
      n_cmp++;
      if (obs_vec() !== exp_vec()) begin
        n_err++; $display("FAIL r_hold cyc%0d: got %b want %b", i, obs_vec(), exp_vec());
      end
    end
    drive(0, 0, 0, 0, 0);
  endtask

  task automatic test_round_win();
    int frcnt = 0, lrcnt = 0;
    drive(0, 0, 0, 1, 0);
    frcnt += int'(bus.fieldReset); lrcnt += int'(bus.L) + int'(bus.R);
    n_cmp++;
    if (bus.scoreR !== 3'd1 || bus.fieldReset !== 1'b1) begin
      n_err++; $display("FAIL round_win: scoreR=%0d fieldReset=%b want 1 1", bus.scoreR, bus.fieldReset);
    end
    for (int i = 0; i < 6; i++) begin
      drive(i == 1, 0, 0, 0, 0);
      frcnt += int'(bus.fieldReset); lrcnt += int'(bus.L) + int'(bus.R);
      n_cmp++;
      if (obs_vec() !== exp_vec()) begin
        n_err++; $display("FAIL round_hold cyc%0d: got %b want %b", i, obs_vec(), exp_vec());
      end
    end
    n_cmp++;
    if (frcnt != H || lrcnt != 0) begin
      n_err++; $display("FAIL hold_len: fieldReset cycles=%0d pulses=%0d want %0d 0", frcnt, lrcnt, H);
    end
  endtask

  task automatic test_double_win();
    int frcnt = 0;
    drive(0, 0, 1, 1, 0);
    frcnt += int'(bus.fieldReset);
    n_cmp++;
    if (bus.scoreL !== 3'd0 || bus.scoreR !== 3'd1) begin
      n_err++; $display("FAIL double_win: scores %0d/%0d want 0/1", bus.scoreL, bus.scoreR);
    end
    for (int i = 0; i < 5; i++) begin
      drive(0, 0, 0, 0, 0);
      frcnt += int'(bus.fieldReset);
      n_cmp++;
      if (obs_vec() !== exp_vec()) begin
        n_err++; $display("FAIL double_hold cyc%0d: got %b want %b", i, obs_vec(), exp_vec());
      end
    end
    n_cmp++;
    if (frcnt != H) begin
      n_err++; $display("FAIL double_hold_len: got %0d want %0d", frcnt, H);
    end
  endtask

  task automatic test_match();
    logic [10:0] frozen;
    for (int w = 0; w < 3; w++) begin
      drive(0, 0, 1, 0, 0);
      for (int i = 0; i < H; i++) begin
        drive(0, 0, 0, 0, 0);
        n_cmp++;
        if (obs_vec() !== exp_vec()) begin
          n_err++; $display("FAIL match_win%0d cyc%0d: got %b want %b", w, i, obs_vec(), exp_vec());
        end
      end
    end
    n_cmp++;
    if (bus.scoreL !== 3'd3 || bus.matchWinner !== 1'b0 || bus.matchOver !== 1'b1 || bus.fieldReset !== 1'b1) begin
      n_err++; $display("FAIL match_over: scoreL=%0d winner=%b over=%b fr=%b want 3 0 1 1",
                        bus.scoreL, bus.matchWinner, bus.matchOver, bus.fieldReset);
    end
    frozen = obs_vec();
    for (int i = 0; i < 8; i++) begin
      drive(i[0], i[1], 1'(i % 3 == 0), 1'(i % 3 == 1), 0);
      n_cmp++;
      if (obs_vec() !== frozen || obs_vec() !== exp_vec()) begin
        n_err++; $display("FAIL match_frozen cyc%0d: got %b want %b", i, obs_vec(), exp_vec());
      end
    end
  endtask

  task automatic test_reset_mid();
    drive(1, 0, 0, 0, 1);
    n_cmp++;
    if (obs_vec() !== 11'd0) begin
      n_err++; $display("FAIL reset_match: got %b want %b", obs_vec(), 11'd0);
    end
    for (int i = 0; i < 3; i++) begin
      drive(1, 0, 0, 0, 0);
      n_cmp++;
      if (bus.L !== 1'b0 || obs_vec() !== exp_vec()) begin
        n_err++; $display("FAIL reset_held_key cyc%0d: got %b want %b", i, obs_vec(), exp_vec());
      end
    end
    drive(0, 0, 0, 1, 0);
    drive(0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 1);
    n_cmp++;
    if (obs_vec() !== 11'd0) begin
      n_err++; $display("FAIL reset_hold: got %b want %b", obs_vec(), 11'd0);
    end
  endtask

  task automatic test_random();
    bit kl = 0, kr = 0;
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 3) == 0) kl = ~kl;
      if ($urandom_range(0, 3) == 0) kr = ~kr;
      drive(kl, kr, $urandom_range(0, 9) == 0, $urandom_range(0, 9) == 0, $urandom_range(0, 99) == 0);
      n_cmp++;
      if (obs_vec() !== exp_vec()) begin
        n_err++; $display("FAIL random cyc%0d: got %b want %b", i, obs_vec(), exp_vec());
      end
    end
  endtask

  initial begin
    bus.keyL = 0; bus.keyR = 0; bus.leftWin = 0; bus.rightWin = 0; Reset = 1;
    test_reset();
    test_press_hold();
    test_tie();
    test_round_win();
    test_double_win();
    test_match();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
